uart_rx_fifo: RTL and testbench

Receive-side buffer that sits directly downstream of the async UART receiver and upstream of the Wishbone UART register block. It captures each byte the receiver flags ready, pulses the receiver's clear input, and stores the byte in a show-ahead FIFO. This replaces the single-byte holding behaviour, so back-to-back characters are not lost while software is slow to poll the data register.

---
 rtl/uart_rx_fifo.sv | 134 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Captures UART receiver bytes into a show-ahead FIFO: 1-cycle ready-to-dout latency, a push into a full FIFO is dropped and flags overrun.
// The optional idle timeout is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
    parameter int DEPTH          = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      rx_data_ready_i,
    input  logic [DATA_WIDTH-1:0]     rx_data_i,
    output logic                      rx_clear_o,
    input  logic                      pop_i,
    output logic [DATA_WIDTH-1:0]     dout_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overrun_o,
    input  logic                      overrun_clr_i,
    output logic                      timeout_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_rx_fifo: DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
        $error("uart_rx_fifo: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, CLEAR, WAIT} state_e;

    state_e                state_q, state_d;
    logic                  rx_clear_q, rx_clear_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  push_req, pop_eff, push_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= WAIT;
            rx_clear_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rx_clear_q <= rx_clear_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_data_ready_i) state_d = CLEAR;
            CLEAR:   state_d = WAIT;
            WAIT:    if (!rx_data_ready_i) state_d = IDLE;
            default: state_d = WAIT;
        endcase
    end

    // The clear pulse is registered: high for the whole cycle spent in CLEAR.
    always_comb begin
        rx_clear_d = (state_d == CLEAR);
    end

    assign push_req = (state_q == IDLE) && rx_data_ready_i;
    assign pop_eff  = pop_i && (count_q != '0);
    assign push_ok  = push_req && ((count_q != CW'(DEPTH)) || pop_eff);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_eff) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_eff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push_req && !push_ok) overrun_d = 1'b1;
        else if (overrun_clr_i)   overrun_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= rx_data_i;
    end

    assign rx_clear_o = rx_clear_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign overrun_o  = overrun_q;
    // Storage is never reset, so the head is masked to zero while empty.
    assign dout_o     = empty_o ? '0 : mem_q[rd_ptr_q];

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_q, idle_d;

    always_comb begin
        idle_d = idle_q;
        if (push_ok || empty_o)                 idle_d = '0;
        else if (idle_q != TW'(TIMEOUT_CYCLES)) idle_d = idle_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) idle_q <= '0;
        else         idle_q <= idle_d;
    end

    assign timeout_o = (idle_q == TW'(TIMEOUT_CYCLES)) && !empty_o;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo with a queue-based reference model and a sticky-flag receiver model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int TO    = 4;

    logic          clk     = 1'b0;
    logic          rst_ni  = 1'b0;
    logic          rdy     = 1'b0;
    logic [DW-1:0] din     = '0;
    logic          pop     = 1'b0;
    logic          ovr_clr = 1'b0;
    logic          rx_clear, empty, full, ovr, tmo;
    logic [DW-1:0] dout;
    logic [4:0]    cnt;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .rx_data_ready_i(rdy), .rx_data_i(din),
        .rx_clear_o(rx_clear), .pop_i(pop), .dout_o(dout), .empty_o(empty),
        .full_o(full), .count_o(cnt), .overrun_o(ovr), .overrun_clr_i(ovr_clr),
        .timeout_o(tmo)
    );

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] q[$];
    bit            exp_clear = 1'b1;
    bit            exp_ovr = 1'b0;
    int            idle = 0;
    bit            clr_seen = 1'b0;
    int            low_edges = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, drive inputs, advance the model.
    task automatic cycle(input bit p, input bit c, input bit want, input logic [DW-1:0] b, output bit sent);
        bit cap, pop_eff, acc, to_exp;
        check_eq("rx_clear", {31'd0, rx_clear}, {31'd0, exp_clear});
        check_eq("empty", {31'd0, empty}, {31'd0, q.size() == 0});
        check_eq("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
        check_eq("count", {27'd0, cnt}, q.size());
        check_eq("overrun", {31'd0, ovr}, {31'd0, exp_ovr});
        check_eq("dout", {24'd0, dout}, (q.size() != 0) ? {24'd0, q[0]} : 32'd0);
`ifdef UART_RX_FIFO_TIMEOUT_EN
        to_exp = (idle == TO) && (q.size() != 0);
`else
        to_exp = 1'b0;
`endif
        check_eq("timeout", {31'd0, tmo}, {31'd0, to_exp});

        // Receiver: the sticky ready flag falls at the edge that samples the clear pulse.
        if (clr_seen) rdy = 1'b0;
        clr_seen = rx_clear;
        sent = 1'b0;
        if (want && !rdy && low_edges >= 1) begin
            rdy  = 1'b1;
            din  = b;
            sent = 1'b1;
        end
        pop     = p;
        ovr_clr = c;

        cap     = sent;
        pop_eff = p && (q.size() > 0);
        acc     = cap && ((q.size() < DEPTH) || pop_eff);
        if (acc || q.size() == 0) idle = 0;
        else if (idle < TO)       idle++;
        if (pop_eff) void'(q.pop_front());
        if (acc)     q.push_back(b);
        if (cap && !acc) exp_ovr = 1'b1;
        else if (c)      exp_ovr = 1'b0;
        exp_clear = cap;
        low_edges = rdy ? 0 : low_edges + 1;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        bit s;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, s);
    endtask

    task automatic pop_cycles(input int n);
        bit s;
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, '0, s);
    endtask

    task automatic send_byte(input logic [DW-1:0] b, input bit p, input bit c);
        bit s;
        int w = 0;
        while (!(rdy == 1'b0 && low_edges >= 1) && w < 20) begin
            cycle(1'b0, 1'b0, 1'b0, '0, s);
            w++;
        end
        check_eq("rx_ready_released", {31'd0, rdy}, 32'd0);
        cycle(p, c, 1'b1, b, s);
    endtask

    task automatic fill_full();
        for (int i = 0; i < DEPTH; i++) send_byte(DW'($urandom_range(0, 255)), 1'b0, 1'b0);
        idle_cycles(2);
    endtask

    initial begin
        bit s;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        idle_cycles(3);

        send_byte(8'h41, 1'b0, 1'b0);
        idle_cycles(3);
        pop_cycles(2);

        for (int i = 0; i < DEPTH; i++) send_byte(DW'(i), 1'b0, 1'b0);
        send_byte(8'hAA, 1'b0, 1'b0);
        idle_cycles(3);
        pop_cycles(DEPTH + 2);
        cycle(1'b0, 1'b1, 1'b0, '0, s);

        fill_full();
        send_byte(8'h55, 1'b1, 1'b0);
        idle_cycles(2);
        pop_cycles(DEPTH + 1);

        fill_full();
        send_byte(8'hA5, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, '0, s);
        idle_cycles(2);
        pop_cycles(DEPTH + 1);

        send_byte(8'h3C, 1'b0, 1'b0);
        idle_cycles(6);
        pop_cycles(1);
        idle_cycles(2);
        send_byte(8'hC3, 1'b1, 1'b0);
        idle_cycles(3);
        pop_cycles(1);

        for (int i = 0; i < 3000; i++) begin
            int pop_pct;
            pop_pct = ((i / 400) % 2 == 0) ? 10 : 60;
            cycle($urandom_range(0, 99) < pop_pct, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 1) == 1, DW'($urandom_range(0, 255)), s);
        end
        pop_cycles(DEPTH + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
